// File: rtl/processador_pkg.sv
// Shared processor definitions: control-unit command codes and the
// handshake state encoding used by the data input block.
package processador_pkg;

    // Control-unit command codes driven on the I/O controle bus
    localparam logic [1:0] CTRL_NENHUM     = 2'b00;
    localparam logic [1:0] CTRL_SAIDA_REG  = 2'b01;
    localparam logic [1:0] CTRL_SAIDA_IMED = 2'b10;
    localparam logic [1:0] CTRL_ENTRADA    = 2'b11;

    // Input handshake state encoding
    localparam logic [1:0] EST_OCIOSO        = 2'b00;
    localparam logic [1:0] EST_ESPERA_BOTAO  = 2'b01;
    localparam logic [1:0] EST_ENTREGA       = 2'b10;
    localparam logic [1:0] EST_ESPERA_SOLTAR = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO        = EST_OCIOSO,
        ESPERA_BOTAO  = EST_ESPERA_BOTAO,
        ENTREGA       = EST_ENTREGA,
        ESPERA_SOLTAR = EST_ESPERA_SOLTAR
    } estado_t;

    function automatic logic eh_entrada(input logic [1:0] controle);
        return controle == CTRL_ENTRADA;
    endfunction

endpackage

// File: rtl/entrada_de_dados_debounce_botao.sv
// Push-button conditioner: two-flop synchronizer followed by a level
// debouncer. The output only follows the input after it has been stable
// for DEBOUNCE_CICLOS consecutive synchronized samples.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic saida
);

    localparam int LARG_CNT = $clog2(DEBOUNCE_CICLOS);
    localparam logic [LARG_CNT-1:0] CNT_FIM = LARG_CNT'(DEBOUNCE_CICLOS - 1);

    logic                r_meta;
    logic                r_sync;
    logic                r_limpo;
    logic [LARG_CNT-1:0] r_cnt;

    // Synchronize the raw button, then accept a new level once it has held long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_limpo <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= entrada;
            r_sync <= r_meta;
            if (r_sync == r_limpo) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_FIM) begin
                r_limpo <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign saida = r_limpo;

endmodule

// File: rtl/entrada_de_dados.sv
// Data input block for the IN instruction: stalls the processor while the
// operator sets the switches and presses confirm, then delivers the
// extended switch word with a one-cycle pronto strobe.
//
// state         | meaning
// OCIOSO        | no request in progress
// ESPERA_BOTAO  | request active, waiting for a fresh button press
// ENTREGA       | dado_entrada valid, pronto high for this cycle
// ESPERA_SOLTAR | waiting for the button to be released before re-arming
module entrada_de_dados
    import processador_pkg::*;
#(
    parameter int LARGURA_CHAVES  = 16,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter bit SINAL_EXT       = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                controle,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botao,
    output logic [31:0]               dado_entrada,
    output logic                      pronto,
    output logic                      aguardando
);

    logic                      w_botao_limpo;
    logic                      w_req;
    logic [31:0]               w_ext;
    logic                      r_limpo_q;
    logic                      r_subida;
    logic [LARGURA_CHAVES-1:0] r_chaves_meta;
    logic [LARGURA_CHAVES-1:0] r_chaves_sync;
    logic [31:0]               r_dado;
    estado_t                   r_estado;

    debounce_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .entrada (botao),
        .saida   (w_botao_limpo)
    );

    assign w_req = eh_entrada(controle);

    generate
        if (LARGURA_CHAVES == 32) begin : g_sem_ext
            assign w_ext = r_chaves_sync;
        end else begin : g_ext
            assign w_ext = {{(32 - LARGURA_CHAVES){SINAL_EXT & r_chaves_sync[LARGURA_CHAVES-1]}},
                            r_chaves_sync};
        end
    endgenerate

    // Synchronize the switches and register the rising edge of the clean button
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chaves_meta <= '0;
            r_chaves_sync <= '0;
            r_limpo_q     <= 1'b0;
            r_subida      <= 1'b0;
        end else begin
            r_chaves_meta <= chaves;
            r_chaves_sync <= r_chaves_meta;
            r_limpo_q     <= w_botao_limpo;
            r_subida      <= w_botao_limpo & ~r_limpo_q;
        end
    end

    // Handshake FSM; a button already held when the request arrives must be released first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_dado   <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_req) begin
                        r_estado <= w_botao_limpo ? ESPERA_SOLTAR : ESPERA_BOTAO;
                    end
                end
                ESPERA_BOTAO: begin
                    if (!w_req) begin
                        r_estado <= OCIOSO;
                    end else if (r_subida) begin
                        r_dado   <= w_ext;
                        r_estado <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    r_estado <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (!w_botao_limpo) begin
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign dado_entrada = r_dado;
    assign pronto       = (r_estado == ENTREGA);
    assign aguardando   = w_req && (r_estado != ENTREGA);

endmodule
